keyboard_event_queue: RTL and testbench

- Sits directly downstream of io_key_display_block's keyboard_keysCurrentState bus.
- Debounces every key line and detects press and release transitions.
- Queues one coded event per transition in a small first-word-fall-through FIFO.
- Produces a stable key vector for DekatronPC Halt/Run/Step, plus an ordered event stream for future monitor/terminal logic.

---
 rtl/keyboard_event_queue.sv | 150 +++++++++++++++
 tb/tb_keyboard_event_queue.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_event_queue.sv
// Debounces a bank of key lines and queues one {key index, level} event per accepted
// transition in a first-word-fall-through FIFO, with a sticky flag for merged changes.
module keyboard_event_queue #(
    parameter int  KEYS           = 40,
    parameter int  DEBOUNCE_TICKS = 4,
    parameter int  FIFO_DEPTH     = 8,
    localparam int CODE_W         = $clog2(KEYS),
    localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              tick,
    input  logic [KEYS-1:0]   keysRaw,
    output logic [KEYS-1:0]   keysStable,
    output logic              eventValid,
    output logic [CODE_W-1:0] eventCode,
    output logic              eventPressed,
    input  logic              eventReady,
    output logic [CNT_W-1:0]  fifoCount,
    output logic              overflow,
    input  logic              clearOverflow
);
    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam int               ENT_W    = CODE_W + 1;
    localparam logic [3:0]       DB_LIMIT = 4'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [KEYS-1:0]       stable_q, stable_d;
    logic [KEYS-1:0][3:0]  db_cnt_q, db_cnt_d;
    logic [KEYS-1:0]       pending_q, pending_d;
    logic [KEYS-1:0]       set_v, clr_v;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ENT_W-1:0]      head_q, head_d;
    logic                  overflow_q, overflow_d;
    logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];

    logic                  sel_found;
    logic [CODE_W-1:0]     sel_idx;
    logic                  pop, push, ovf_hit;
    logic [ENT_W-1:0]      push_data;

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        set_v    = '0;
        if (tick) begin
            for (int i = 0; i < KEYS; i++) begin
                if (keysRaw[i] == stable_q[i]) begin
                    db_cnt_d[i] = '0;
                end else if (db_cnt_q[i] + 4'd1 == DB_LIMIT) begin
                    stable_d[i] = keysRaw[i];
                    db_cnt_d[i] = '0;
                    set_v[i]    = 1'b1;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Descending scan so the lowest pending index is the one left selected.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = CODE_W'(i);
            end
        end
    end

    always_comb begin
        pop       = (count_q != '0) && eventReady;
        push      = sel_found && ((count_q != FULL_CNT) || pop);
        push_data = {sel_idx, stable_q[sel_idx]};

        clr_v = '0;
        if (push) begin
            clr_v[sel_idx] = 1'b1;
        end
        // A second accepted change before the first was queued merges into one event.
        ovf_hit   = |(set_v & pending_q & ~clr_v);
        pending_d = (pending_q & ~clr_v) | set_v;

        if (ovf_hit) begin
            overflow_d = 1'b1;
        end else if (clearOverflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        // The entry being written this edge may itself become the new head.
        if (count_d == '0) begin
            head_d = '0;
        end else if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stable_q   <= '0;
            db_cnt_q   <= '0;
            pending_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            stable_q   <= stable_d;
            db_cnt_q   <= db_cnt_d;
            pending_q  <= pending_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign keysStable   = stable_q;
    assign eventValid   = (count_q != '0);
    assign eventCode    = head_q[ENT_W-1:1];
    assign eventPressed = head_q[0];
    assign fifoCount    = count_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_keyboard_event_queue.sv
// Bench for keyboard_event_queue: table vectors, directed corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_keyboard_event_queue;
    localparam int KEYS  = 40;
    localparam int DBT   = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 6;
    localparam int NW    = 4;

    logic            Clk = 1'b0;
    logic            Rst_n = 1'b0;
    logic            tick = 1'b0;
    logic            eventReady = 1'b0;
    logic            clearOverflow = 1'b0;
    logic [KEYS-1:0] keysRaw = '0;
    logic [KEYS-1:0] keysStable;
    logic            eventValid, eventPressed, overflow;
    logic [CW-1:0]   eventCode;
    logic [NW-1:0]   fifoCount;

    int checks = 0;
    int failures = 0;

    keyboard_event_queue #(.KEYS(KEYS), .DEBOUNCE_TICKS(DBT), .FIFO_DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .tick(tick), .keysRaw(keysRaw), .keysStable(keysStable),
        .eventValid(eventValid), .eventCode(eventCode), .eventPressed(eventPressed),
        .eventReady(eventReady), .fifoCount(fifoCount), .overflow(overflow),
        .clearOverflow(clearOverflow)
    );

    always #5 Clk = ~Clk;

    // Reference model: stable levels, per-key tick counts, pending set and an event queue.
    logic [KEYS-1:0] m_stable, m_pend;
    int              m_cnt [KEYS];
    bit              m_ovf;
    int              mq [$];

    function automatic void model_reset();
        m_stable = '0;
        m_pend   = '0;
        m_ovf    = 1'b0;
        for (int i = 0; i < KEYS; i++) m_cnt[i] = 0;
        mq.delete();
    endfunction

    function automatic void model_step();
        logic [KEYS-1:0] set_v = '0;
        logic [KEYS-1:0] clr_v = '0;
        bit pop, push, hit;
        int sel = -1;
        int ev  = 0;
        pop  = (mq.size() != 0) && eventReady;
        push = 1'b0;
        for (int i = 0; i < KEYS; i++) if (m_pend[i] && sel < 0) sel = i;
        if (sel >= 0 && (mq.size() < DEPTH || pop)) begin
            push = 1'b1;
            clr_v[sel] = 1'b1;
            ev = sel * 2 + int'(m_stable[sel]);
        end
        if (tick) begin
            for (int i = 0; i < KEYS; i++) begin
                if (keysRaw[i] == m_stable[i]) m_cnt[i] = 0;
                else begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DBT) begin
                        m_stable[i] = keysRaw[i];
                        m_cnt[i] = 0;
                        set_v[i] = 1'b1;
                    end
                end
            end
        end
        hit    = |(set_v & m_pend & ~clr_v);
        m_pend = (m_pend & ~clr_v) | set_v;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(ev);
        if (hit) m_ovf = 1'b1;
        else if (clearOverflow) m_ovf = 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_stable", keysStable, m_stable);
        chk("model_valid", eventValid, mq.size() != 0);
        chk("model_count", fifoCount, mq.size());
        chk("model_overflow", overflow, m_ovf);
        if (mq.size() != 0) begin
            chk("model_code", eventCode, mq[0] >> 1);
            chk("model_pressed", eventPressed, mq[0] & 1);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic drain();
        eventReady = 1'b1;
        repeat (40) step();
        eventReady = 1'b0;
    endtask

    typedef struct {
        logic tk, r5, rdy;
        logic e_st, e_v;
        int   e_code;
        logic e_p;
        int   e_cnt;
    } vec_t;
    vec_t tbl [11];

    initial begin
        int n12;
        logic p12;

        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 1, 0, 1, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 1, 1, 5, 1, 1};
        tbl[10] = '{0, 1, 1, 1, 0, 0, 0, 0};

        model_reset();
        #12;
        chk("rst_stable", keysStable, 0);
        chk("rst_valid", eventValid, 0);
        chk("rst_count", fifoCount, 0);
        chk("rst_code", eventCode, 0);
        chk("rst_pressed", eventPressed, 0);
        chk("rst_overflow", overflow, 0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Debounce of key 5: short burst rejected, full burst accepted.
        for (int r = 0; r < 11; r++) begin
            tick = tbl[r].tk;
            keysRaw[5] = tbl[r].r5;
            eventReady = tbl[r].rdy;
            step();
            chk($sformatf("tbl%0d_stable5", r), keysStable[5], tbl[r].e_st);
            chk($sformatf("tbl%0d_valid", r), eventValid, tbl[r].e_v);
            chk($sformatf("tbl%0d_count", r), fifoCount, tbl[r].e_cnt);
            if (tbl[r].e_v) begin
                chk($sformatf("tbl%0d_code", r), eventCode, tbl[r].e_code);
                chk($sformatf("tbl%0d_pressed", r), eventPressed, tbl[r].e_p);
            end
        end
        tick = 1'b0;
        eventReady = 1'b0;
        keysRaw[5] = 1'b0;
        ticks(4);
        drain();

        // Three keys accepted on the same edge queue in index order.
        keysRaw[2] = 1'b1; keysRaw[7] = 1'b1; keysRaw[30] = 1'b1;
        ticks(4);
        chk("sim_stable", keysStable, (64'd1 << 2) | (64'd1 << 7) | (64'd1 << 30));
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("sim_count", fifoCount, k);
            chk("sim_head", eventCode, 2);
        end
        eventReady = 1'b1;
        step();
        chk("sim_second", eventCode, 7);
        step();
        chk("sim_third", eventCode, 30);
        step();
        chk("sim_empty", eventValid, 0);
        eventReady = 1'b0;
        keysRaw = '0;
        ticks(4);
        drain();

        // Ten presses against an eight-entry queue, then push/pop while full.
        keysRaw[19:10] = '1;
        ticks(4);
        repeat (12) step();
        chk("full_count", fifoCount, 8);
        eventReady = 1'b1;
        for (int k = 0; k < 10; k++) begin
            chk("full_order_code", eventCode, 10 + k);
            chk("full_order_pressed", eventPressed, 1);
            step();
            if (k == 0) chk("push_pop_full_count", fifoCount, 8);
        end
        chk("full_done_valid", eventValid, 0);
        chk("full_overflow", overflow, 0);
        eventReady = 1'b0;
        keysRaw = '0;
        ticks(4);
        drain();

        // Key 12 pressed and released while the queue is full.
        keysRaw[27:20] = '1;
        ticks(4);
        repeat (10) step();
        chk("dbl_full", fifoCount, 8);
        keysRaw[12] = 1'b1;
        ticks(4);
        chk("dbl_press_stable", keysStable[12], 1);
        chk("dbl_no_ovf_yet", overflow, 0);
        keysRaw[12] = 1'b0;
        ticks(4);
        chk("dbl_release_stable", keysStable[12], 0);
        chk("dbl_overflow", overflow, 1);
        n12 = 0;
        p12 = 1'b1;
        eventReady = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (eventValid && eventCode == 12) begin
                n12++;
                p12 = eventPressed;
            end
            step();
        end
        eventReady = 1'b0;
        chk("dbl_key12_events", n12, 1);
        chk("dbl_key12_level", p12, 0);
        clearOverflow = 1'b1;
        step();
        clearOverflow = 1'b0;
        chk("dbl_cleared", overflow, 0);
        keysRaw = '0;
        ticks(4);
        drain();

        // Asynchronous reset with three events held.
        keysRaw[2:0] = 3'b111;
        ticks(4);
        repeat (3) step();
        chk("arst_pre_count", fifoCount, 3);
        #3;
        Rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_stable", keysStable, 0);
        chk("arst_valid", eventValid, 0);
        chk("arst_count", fifoCount, 0);
        chk("arst_code", eventCode, 0);
        chk("arst_pressed", eventPressed, 0);
        chk("arst_overflow", overflow, 0);
        @(negedge Clk);
        @(negedge Clk);
        keysRaw = '0;
        Rst_n = 1'b1;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) keysRaw[$urandom_range(0, 11)] ^= 1'b1;
            tick = ($urandom_range(0, 2) == 0);
            eventReady = ($urandom_range(0, 3) == 0);
            clearOverflow = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
